// File: rtl/word_src.sv
// Burst word source: valid/ready stream of 32-bit words with LFSR upper bits and a policy-driven a[0].
// Also reports the odd/even counts of words accepted in the current burst.
module word_src #(
   parameter logic [31:0] SEED = 32'h0000_0001,
   parameter logic [31:0] TAPS = 32'h8020_0003
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  mode,
   input  logic [7:0]  burst_len,
   output logic [31:0] a,
   output logic        a_valid,
   input  logic        a_ready,
   output logic        busy,
   output logic        done,
   output logic [7:0]  odd_cnt,
   output logic [7:0]  even_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] lfsr_q, lfsr_d;
   logic        phase_q, phase_d;
   logic [7:0]  rem_q, rem_d;
   logic [1:0]  mode_q, mode_d;
   logic [7:0]  odd_q, odd_d;
   logic [7:0]  even_q, even_d;
   logic        bit0;
   logic        hs;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, regardless of statement order.
      if (!rst) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED;
         phase_q <= 1'b1;
         rem_q   <= 8'd0;
         mode_q  <= 2'd0;
         odd_q   <= 8'd0;
         even_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         phase_q <= phase_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         odd_q   <= odd_d;
         even_q  <= even_d;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = (burst_len != 8'd0) ? S_RUN : S_DONE;
         S_RUN:  if (hs && rem_q == 8'd1) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      a_valid = (state_q == S_RUN);
      busy    = (state_q != S_IDLE);
      done    = (state_q == S_DONE);
      hs      = a_valid && a_ready;
      unique case (mode_q)
         2'b00: bit0 = lfsr_q[0];
         2'b01: bit0 = 1'b1;
         2'b10: bit0 = 1'b0;
         default: bit0 = phase_q;
      endcase
      a        = a_valid ? {lfsr_q[31:1], bit0} : 32'd0;
      odd_cnt  = odd_q;
      even_cnt = even_q;
   end

   // Datapath only moves on an accepted start or a handshake, so backpressure freezes everything.
   always_comb begin
      lfsr_d  = lfsr_q;
      phase_d = phase_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      odd_d   = odd_q;
      even_d  = even_q;
      if (state_q == S_IDLE && start) begin
         mode_d  = mode;
         rem_d   = burst_len;
         phase_d = 1'b1;
         odd_d   = 8'd0;
         even_d  = 8'd0;
      end else if (hs) begin
         lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
         phase_d = ~phase_q;
         rem_d   = rem_q - 8'd1;
         if (bit0) odd_d  = odd_q + 8'd1;
         else      even_d = even_q + 8'd1;
      end
   end

endmodule

// File: tb/tb_word_src.sv
// Self-checking bench for word_src: directed plan steps plus randomized bursts against a word-list model.
module tb_word_src;

   localparam logic [31:0] SEED = 32'h0000_0001;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic [7:0]  burst_len;
   logic [31:0] a;
   logic        a_valid;
   logic        a_ready;
   logic        busy;
   logic        done;
   logic [7:0]  odd_cnt;
   logic [7:0]  even_cnt;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] m_lfsr;

   word_src #(.SEED(SEED), .TAPS(TAPS)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .burst_len(burst_len),
      .a(a), .a_valid(a_valid), .a_ready(a_ready), .busy(busy), .done(done),
      .odd_cnt(odd_cnt), .even_cnt(even_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
   endfunction

   // Word index k of a burst: mode 11 gives odd on even indices (first word odd).
   function automatic logic policy_bit(input logic [1:0] md, input int k, input logic l0);
      case (md)
         2'b00: return l0;
         2'b01: return 1'b1;
         2'b10: return 1'b0;
         default: return (k % 2) == 0;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      start = 1'b0;
      a_ready = 1'b0;
      cycle();
      rst = 1'b1;
      m_lfsr = SEED;
   endtask

   // stall_fixed >= 0: exactly that many stall cycles before each accept; otherwise random stall_pct.
   // abort_after >= 0: apply reset once that many words have been accepted.
   task automatic run_burst(input logic [1:0] md, input logic [7:0] len, input int stall_fixed,
                            input int stall_pct, input bit noisy_start, input int abort_after);
      logic [31:0] words[$];
      logic [31:0] l;
      int odd_e = 0, even_e = 0, k = 0, stall = 0, budget = 3000;
      logic ready;
      l = m_lfsr;
      for (int i = 0; i < int'(len); i++) begin
         words.push_back({l[31:1], policy_bit(md, i, l[0])});
         l = lfsr_next(l);
      end
      check("idle_busy", 32'(busy), 32'd0);
      start = 1'b1; mode = md; burst_len = len;
      cycle();
      start = 1'b0; mode = 2'($urandom); burst_len = 8'($urandom);
      if (len == 8'd0) begin
         check("zero_done", 32'(done), 32'd1);
         check("zero_valid", 32'(a_valid), 32'd0);
         check("zero_odd", 32'(odd_cnt), 32'd0);
         check("zero_even", 32'(even_cnt), 32'd0);
         cycle();
         check("zero_idle_busy", 32'(busy), 32'd0);
         check("zero_idle_done", 32'(done), 32'd0);
         check("zero_idle_valid", 32'(a_valid), 32'd0);
         return;
      end
      while (k < int'(len)) begin
         check("run_valid", 32'(a_valid), 32'd1);
         check("run_busy", 32'(busy), 32'd1);
         check("run_done", 32'(done), 32'd0);
         check($sformatf("word%0d", k), a, words[k]);
         check("run_odd", 32'(odd_cnt), 32'(odd_e));
         check("run_even", 32'(even_cnt), 32'(even_e));
         if (abort_after == k) begin
            rst = 1'b0;
            a_ready = 1'b1;
            cycle();
            rst = 1'b1;
            a_ready = 1'b0;
            m_lfsr = SEED;
            check("abort_valid", 32'(a_valid), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_a", a, 32'd0);
            check("abort_odd", 32'(odd_cnt), 32'd0);
            check("abort_even", 32'(even_cnt), 32'd0);
            cycle();
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
            return;
         end
         if (stall_fixed >= 0) ready = (stall == stall_fixed);
         else                  ready = ($urandom_range(0, 99) >= stall_pct);
         a_ready = ready;
         if (noisy_start) begin
            start = 1'b1;
            mode = 2'($urandom);
            burst_len = 8'($urandom) | 8'd1;
         end
         cycle();
         if (ready) begin
            if (words[k][0]) odd_e++;
            else             even_e++;
            k++;
            stall = 0;
         end else begin
            stall++;
         end
         budget--;
         if (budget == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL burst_timeout: accepted %0d of %0d words", k, len);
            return;
         end
      end
      m_lfsr = l;
      check("end_done", 32'(done), 32'd1);
      check("end_valid", 32'(a_valid), 32'd0);
      check("end_a", a, 32'd0);
      check("end_busy", 32'(busy), 32'd1);
      check("end_odd", 32'(odd_cnt), 32'(odd_e));
      check("end_even", 32'(even_cnt), 32'(even_e));
      a_ready = 1'($urandom);
      cycle();
      start = 1'b0;
      a_ready = 1'b0;
      check("post_busy", 32'(busy), 32'd0);
      check("post_done", 32'(done), 32'd0);
      check("post_valid", 32'(a_valid), 32'd0);
      check("post_odd", 32'(odd_cnt), 32'(odd_e));
      check("post_even", 32'(even_cnt), 32'(even_e));
      cycle();
      check("still_idle", 32'(busy), 32'd0);
      check("hold_odd", 32'(odd_cnt), 32'(odd_e));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; a_ready = 1'b0; mode = 2'd0; burst_len = 8'd0;
      cycle();
      cycle();
      check("rst_a", a, 32'd0);
      check("rst_valid", 32'(a_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_odd", 32'(odd_cnt), 32'd0);
      check("rst_even", 32'(even_cnt), 32'd0);
      rst = 1'b1;
      m_lfsr = SEED;
      cycle();

      run_burst(2'b01, 8'd3, 0, 0, 1'b0, -1);
      do_reset();
      run_burst(2'b11, 8'd4, 0, 0, 1'b0, -1);
      do_reset();
      run_burst(2'b10, 8'd2, 3, 0, 1'b0, -1);
      run_burst(2'b00, 8'd0, 0, 0, 1'b0, -1);
      run_burst(2'b01, 8'd6, -1, 30, 1'b1, -1);
      do_reset();
      run_burst(2'b01, 8'd5, 0, 0, 1'b0, 2);
      run_burst(2'b01, 8'd3, 0, 0, 1'b0, -1);

      for (int i = 0; i < 25; i++) begin
         run_burst(2'($urandom), 8'($urandom_range(0, 24)), -1, int'($urandom_range(0, 60)),
                   1'($urandom), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
